barrel_shifter_pipe: RTL

Parametrised, pipelined barrel shifter. It is the successor to the team's fixed 4-bit mux-based right rotator. It generalises data width and adds four shift modes (rotate right/left, logical right, arithmetic right). Each shift-amount bit is resolved in its own registered stage, and a valid/ready handshake on both sides lets it sit inline in streaming datapaths between producer and consumer blocks.

---
 rtl/barrel_pkg.sv | 16 +
 rtl/barrel_shifter_pipe_if.sv | 24 ++
 rtl/barrel_stage.sv | 51 +++++
 rtl/barrel_shifter_pipe.sv | 52 +++++
 4 files changed

// File: rtl/barrel_pkg.sv
// rtl/barrel_pkg.sv - shared mode encodings and width helper for the barrel shifter
package barrel_pkg;

   localparam logic [1:0] MODE_ROR = 2'b00;
   localparam logic [1:0] MODE_ROL = 2'b01;
   localparam logic [1:0] MODE_SRL = 2'b10;
   localparam logic [1:0] MODE_SRA = 2'b11;

   function automatic int clog2(input int n);
      int r;
      for (r = 0; (1 << r) < n; r++) begin
      end
      return r;
   endfunction

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// rtl/barrel_shifter_pipe_if.sv - input/output stream bundle for barrel_shifter_pipe
interface barrel_shifter_pipe_if #(parameter int WIDTH = 8);
   import barrel_pkg::*;
   localparam int SHW = clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_shamt;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, in_shamt, in_mode, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_mode, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/barrel_stage.sv
// rtl/barrel_stage.sv - one registered stage shifting by SHIFT when its shamt bit is set
module barrel_stage
   import barrel_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int SHIFT = 1,
   localparam int SHW   = clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv,
   input  logic [WIDTH-1:0] d_in,
   input  logic [SHW-1:0]   sa_in,
   input  logic [1:0]       md_in,
   input  logic             v_in,
   output logic [WIDTH-1:0] d_out,
   output logic [SHW-1:0]   sa_out,
   output logic [1:0]       md_out,
   output logic             v_out
);
   localparam int BIT = clog2(SHIFT);

   logic [WIDTH-1:0] shifted;

   // SRA takes the current MSB: earlier stages already sign-filled the word
   always_comb begin
      shifted = d_in;
      if (sa_in[BIT]) begin
         case (md_in)
            MODE_ROR: shifted = (d_in >> SHIFT) | (d_in << (WIDTH - SHIFT));
            MODE_ROL: shifted = (d_in << SHIFT) | (d_in >> (WIDTH - SHIFT));
            MODE_SRL: shifted = d_in >> SHIFT;
            default:  shifted = $unsigned($signed(d_in) >>> SHIFT);
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d_out  <= '0;
         sa_out <= '0;
         md_out <= '0;
         v_out  <= 1'b0;
      end else if (adv) begin
         d_out  <= shifted;
         sa_out <= sa_in;
         md_out <= md_in;
         v_out  <= v_in;
      end
   end
endmodule

// File: rtl/barrel_shifter_pipe.sv
// rtl/barrel_shifter_pipe.sv - pipelined barrel shifter, one shamt bit resolved per stage
module barrel_shifter_pipe
   import barrel_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   barrel_shifter_pipe_if.slave bus
);
   localparam int SHW = clog2(WIDTH);

   logic                  adv;
   logic [SHW:0][WIDTH-1:0] d;
   logic [SHW:0][SHW-1:0]   sa;
   logic [SHW:0][1:0]       md;
   logic [SHW:0]            v;
   logic                    unused_tail;

   // whole pipe moves or whole pipe holds; bubbles are only dropped at the output
   assign adv = bus.out_ready | ~v[SHW];

   assign d[0]  = bus.in_data;
   assign sa[0] = bus.in_shamt;
   assign md[0] = bus.in_mode;
   assign v[0]  = bus.in_valid;

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      barrel_stage #(
         .WIDTH (WIDTH),
         .SHIFT (1 << k)
      ) u_stage (
         .clk    (clk),
         .rst_n  (rst_n),
         .adv    (adv),
         .d_in   (d[k]),
         .sa_in  (sa[k]),
         .md_in  (md[k]),
         .v_in   (v[k]),
         .d_out  (d[k+1]),
         .sa_out (sa[k+1]),
         .md_out (md[k+1]),
         .v_out  (v[k+1])
      );
   end

   assign unused_tail = ^{sa[SHW], md[SHW]};

   assign bus.in_ready  = adv;
   assign bus.out_valid = v[SHW];
   assign bus.out_data  = d[SHW];
endmodule
